// File: rtl/clock_period_meter.sv
// Measures the period and high time of async sig_in in clock_in cycles; results 1 cycle after the synced rise, valid is a strobe with no backpressure.
// Define PERIOD_METER_DUTY_EN to build the high-time counter; without it high_time reads 0.
module clock_period_meter #(
  parameter int WIDTH = 29
) (
  input  logic             clock_in,
  input  logic             reset_n,
  input  logic             sig_in,
  input  logic             enable,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             valid,
  output logic             timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             prev_q, prev_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;
  logic             rise;
  logic             cnt_load, cnt_clear, cnt_inc;

  always_comb begin
    sync1_d = sig_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  assign rise = sync2_q & ~prev_q;

  // A rise always wins over saturation, so a period of exactly CNT_MAX is still reported.
  always_comb begin
    state_d   = state_q;
    period_d  = period_q;
    valid_d   = 1'b0;
    timeout_d = timeout_q;
    cnt_load  = 1'b0;
    cnt_clear = 1'b0;
    cnt_inc   = 1'b0;
    if (!enable) begin
      state_d   = IDLE;
      cnt_clear = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_clear = 1'b1;
          state_d   = ARM;
        end
        ARM: begin
          if (rise) begin
            cnt_load = 1'b1;
            state_d  = MEAS;
          end
        end
        MEAS: begin
          if (rise) begin
            period_d  = cnt_q;
            valid_d   = 1'b1;
            timeout_d = 1'b0;
            cnt_load  = 1'b1;
          end else if (cnt_q == CNT_MAX) begin
            timeout_d = 1'b1;
            cnt_clear = 1'b1;
            state_d   = ARM;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        default: begin
          state_d   = IDLE;
          cnt_clear = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clear) begin
      cnt_d = '0;
    end else if (cnt_load) begin
      cnt_d = CNT_ONE;
    end else if (cnt_inc) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      prev_q    <= 1'b0;
      cnt_q     <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      prev_q    <= prev_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  assign period  = period_q;
  assign valid   = valid_q;
  assign timeout = timeout_q;

`ifdef PERIOD_METER_DUTY_EN
  logic             fall;
  logic             fall_seen_q, fall_seen_d;
  logic [WIDTH-1:0] hcnt_q, hcnt_d;
  logic [WIDTH-1:0] high_time_q, high_time_d;

  assign fall = ~sync2_q & prev_q;

  // hcnt follows cnt's load/clear so it can never exceed it and needs no saturation of its own.
  always_comb begin
    hcnt_d      = hcnt_q;
    fall_seen_d = fall_seen_q;
    high_time_d = high_time_q;
    if (valid_d) begin
      high_time_d = hcnt_q;
    end
    if (cnt_clear) begin
      hcnt_d      = '0;
      fall_seen_d = 1'b0;
    end else if (cnt_load) begin
      hcnt_d      = CNT_ONE;
      fall_seen_d = 1'b0;
    end else if (cnt_inc) begin
      if (sync2_q && !fall_seen_q) begin
        hcnt_d = hcnt_q + CNT_ONE;
      end
      if (fall) begin
        fall_seen_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      hcnt_q      <= '0;
      fall_seen_q <= 1'b0;
      high_time_q <= '0;
    end else begin
      hcnt_q      <= hcnt_d;
      fall_seen_q <= fall_seen_d;
      high_time_q <= high_time_d;
    end
  end

  assign high_time = high_time_q;
`else
  assign high_time = '0;
`endif

endmodule

// File: tb/tb_clock_period_meter.sv
// Bench for clock_period_meter: directed and random waveforms, each valid compared with periods taken from the driven rise/fall times.
module tb_clock_period_meter;

  localparam int W = 8;

  logic         clock_in = 1'b0;
  logic         reset_n;
  logic         sig_in;
  logic         enable;
  logic [W-1:0] period;
  logic [W-1:0] high_time;
  logic         valid;
  logic         timeout;

  clock_period_meter #(.WIDTH(W)) dut (
    .clock_in (clock_in),
    .reset_n  (reset_n),
    .sig_in   (sig_in),
    .enable   (enable),
    .period   (period),
    .high_time(high_time),
    .valid    (valid),
    .timeout  (timeout)
  );

  initial forever #5 clock_in = ~clock_in;

  typedef struct {
    int p;
    int h;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   run_id   = 0;
  int   cyc      = 0;
  int   prev_h   = 0;
  int   prev_l   = 0;
  bit   have_prev = 1'b0;

  always @(posedge clock_in) cyc = cyc + 1;

  function automatic int exp_high(int h);
`ifdef PERIOD_METER_DUTY_EN
    return h;
`else
    return 0;
`endif
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Reference model: every driven rise that follows another rise in the same run closes a period.
  task automatic mark_rise(int h, int l, bit expect_en);
    exp_t e;
    if (expect_en && have_prev) begin
      e.p = prev_h + prev_l;
      e.h = exp_high(prev_h);
      exp_q.push_back(e);
    end
    prev_h    = h;
    prev_l    = l;
    have_prev = expect_en;
  endtask

  task automatic drive_period(int h, int l, bit expect_en);
    mark_rise(h, l, expect_en);
    sig_in = 1'b1;
    repeat (h) @(negedge clock_in);
    sig_in = 1'b0;
    repeat (l) @(negedge clock_in);
  endtask

  task automatic wave(int h, int l, int n, bit expect_en);
    for (int i = 0; i < n; i++) drive_period(h, l, expect_en);
  endtask

  task automatic start_run();
    run_id++;
    have_prev = 1'b0;
    enable    = 1'b1;
    repeat (3) @(negedge clock_in);
  endtask

  task automatic end_run(string tag);
    repeat (6) @(negedge clock_in);
    check(tag, exp_q.size(), 0);
    exp_q.delete();
    enable = 1'b0;
    repeat (3) @(negedge clock_in);
  endtask

  // Monitor: valids must match the model queue and be one period apart; outputs hold otherwise.
  int   mon_run   = -1;
  int   last_cyc  = 0;
  bit   gap_armed = 1'b0;
  int   held_p    = 0;
  int   held_h    = 0;
  exp_t mon_e;

  always @(negedge clock_in) begin
    if (!reset_n) begin
      held_p    = 0;
      held_h    = 0;
      gap_armed = 1'b0;
    end else begin
      if (mon_run != run_id) begin
        gap_armed = 1'b0;
        mon_run   = run_id;
      end
      if (valid === 1'b1) begin
        check("valid_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          check("period", period, mon_e.p);
          check("high_time", high_time, mon_e.h);
          if (gap_armed) check("valid_gap", cyc - last_cyc, mon_e.p);
          gap_armed = 1'b1;
          last_cyc  = cyc;
          held_p    = mon_e.p;
          held_h    = mon_e.h;
        end
      end else begin
        check("period_held", period, held_p);
        check("high_time_held", high_time, held_h);
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    sig_in  = 1'b0;
    enable  = 1'b1;

    // Reset with a toggling input and enable high.
    for (int i = 0; i < 10; i++) begin
      @(negedge clock_in);
      sig_in = ~sig_in;
    end
    @(negedge clock_in);
    check("rst_period", period, 0);
    check("rst_high_time", high_time, 0);
    check("rst_valid", valid, 0);
    check("rst_timeout", timeout, 0);
    sig_in = 1'b0;
    repeat (4) @(negedge clock_in);
    reset_n = 1'b1;
    start_run();
    wave(6, 6, 3, 1'b1);
    end_run("drain_after_reset");

    // 10/10 square wave and 3/4 odd wave.
    start_run();
    wave(10, 10, 6, 1'b1);
    end_run("drain_square");
    start_run();
    wave(3, 4, 6, 1'b1);
    end_run("drain_odd");

    // One rise then held low: timeout after 2^W-1 cycles, results held.
    start_run();
    mark_rise(5, 0, 1'b0);
    sig_in = 1'b1;
    repeat (5) @(negedge clock_in);
    sig_in = 1'b0;
    repeat (245) @(negedge clock_in);
    check("timeout_not_yet", timeout, 0);
    repeat (15) @(negedge clock_in);
    check("timeout_set", timeout, 1);
    check("timeout_period_held", period, 7);
    check("timeout_high_held", high_time, exp_high(3));
    wave(5, 5, 4, 1'b1);
    check("timeout_cleared", timeout, 0);
    // Period of exactly 2^W-1 is reported, then constant high times out.
    wave(100, 155, 1, 1'b1);
    mark_rise(300, 0, 1'b1);
    sig_in = 1'b1;
    repeat (10) @(negedge clock_in);
    check("max_period_no_timeout", timeout, 0);
    repeat (260) @(negedge clock_in);
    check("const_high_timeout", timeout, 1);
    check("const_high_period_held", period, 255);
    check("const_high_high_held", high_time, exp_high(100));
    sig_in = 1'b0;
    end_run("drain_timeout");

    // Enable dropped mid-period, input keeps toggling, then re-armed.
    start_run();
    wave(8, 8, 3, 1'b1);
    enable = 1'b0;
    wave(8, 8, 3, 1'b0);
    check("gap_period_held", period, 16);
    check("gap_high_held", high_time, exp_high(8));
    check("gap_queue_empty", exp_q.size(), 0);
    start_run();
    wave(6, 5, 4, 1'b1);
    end_run("drain_rearm");

    // Random periods including the 1-high/1-low minimum.
    start_run();
    drive_period(1, 1, 1'b1);
    drive_period(1, 1, 1'b1);
    for (int i = 0; i < 14; i++) begin
      drive_period(int'($urandom_range(20, 1)), int'($urandom_range(20, 1)), 1'b1);
    end
    drive_period(2, 2, 1'b1);
    end_run("drain_random");

    // Asynchronous reset in the middle of a period-12 measurement.
    start_run();
    wave(6, 6, 3, 1'b1);
    sig_in = 1'b1;
    repeat (3) @(negedge clock_in);
    reset_n = 1'b0;
    #1;
    check("midrst_period", period, 0);
    check("midrst_high_time", high_time, 0);
    check("midrst_valid", valid, 0);
    check("midrst_timeout", timeout, 0);
    exp_q.delete();
    sig_in = 1'b0;
    repeat (4) @(negedge clock_in);
    reset_n = 1'b1;
    start_run();
    wave(6, 6, 3, 1'b1);
    end_run("drain_after_midrst");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
